enemy_fire_scheduler: RTL
=========================

Name: enemy_fire_scheduler

Overview:
Decides when, and from which enemy, the single enemy projectile is launched. Only one enemy shot may be in flight at a time, so this block arbitrates that shared shot among the LINHAS*COLUNAS formation. It picks a pseudo-random column, targets the bottom-most live enemy in that column, waits until the projectile is free, then issues a one-cycle fire pulse. It sits between the enemy alive vector and the enemy-projectile block, and replaces the ad-hoc enemy ID selection in the top level.

Parameters:
COLUNAS, 13, formation columns (max 16)
LINHAS, 5, formation rows (max 8)
COOLDOWN_BASE, 5000000, cycles between shots at speed 0 (100 ms at 50 MHz)
COOLDOWN_STEP, 250000, cycles removed per speed unit
COOLDOWN_MIN, 1000000, floor on the effective cooldown
LFSR_SEED, 16'hACE1, reset value of the LFSR (must be nonzero)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
enable  in  1  high while the game is in the playing state
vivo  in  LINHAS*COLUNAS  enemy alive bits; index = row*COLUNAS+col; row 0 is the top row
shot_busy  in  1  enemy projectile currently in flight
speed  in  5  formation speed level
fire  out  1  one-cycle launch pulse
fire_col  out  4  column of the last target
fire_row  out  3  row of the last target
fire_idx  out  7  row*COLUNAS+col of the last target
shots_fired  out  16  count of shots launched, wraps at 65535->0

Behaviour:
- Reset (reset=0, asynchronous): state=S_IDLE; fire=0; fire_col=0; fire_row=0; fire_idx=0; shots_fired=0; LFSR=LFSR_SEED. Applies immediately in any state, including mid-scan.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every clock while out of reset, in every state.
- eff = COOLDOWN_BASE - speed*COOLDOWN_STEP.
  - Compute in at least 30 bits.
  - If the product is >= COOLDOWN_BASE, or eff < COOLDOWN_MIN, use eff = COOLDOWN_MIN.
  - eff is sampled when S_COOL is entered.
- S_IDLE: all outputs hold. When enable=1 is sampled, go to S_COOL.
- S_COOL:
  - Stays exactly eff cycles; the counter is loaded on entry and decremented each cycle.
  - Then go to S_PICK.
- S_PICK (1 cycle):
  - start = LFSR[3:0]; if start >= COLUNAS, subtract COLUNAS.
  - col=start, tries=0; go to S_SCAN.
- S_SCAN (one column per cycle):
  - Combinationally find the highest row r with vivo[r*COLUNAS+col]=1.
  - If found: latch tgt_col=col, tgt_row=r; go to S_WAIT.
  - Else if tries==COLUNAS-1: formation empty, go to S_COOL without firing.
  - Else: col=(col==COLUNAS-1)?0:col+1; tries+1.
- S_WAIT:
  - If vivo[tgt] is 0: go to S_PICK.
  - Else if shot_busy=0 in the same sample:
    - register fire=1;
    - fire_col/row/idx <= target;
    - shots_fired+1;
    - go to S_COOL.
  - Otherwise hold.
  - If the kill and shot_busy=0 occur on the same sample, the kill wins (no fire).
- fire is high for exactly one cycle, the first cycle of the next S_COOL.
- Latency: with cycle 0 = first S_COOL cycle, scan hit first try and shot_busy=0, fire is high at cycle eff+3.
- enable=0 sampled in any state: next state S_IDLE, fire=0.
  - A pending fire is discarded.
  - fire_col/row/idx and shots_fired hold.
- The only arithmetic wrap is shots_fired; column index wrap is as defined in S_SCAN.

Decomposition:
- Shared package space_invaders_pkg holds:
  - COLUNAS and LINHAS;
  - the state encoding (S_IDLE, S_COOL, S_PICK, S_SCAN, S_WAIT, 3 bits);
  - the LFSR polynomial constant.
- One sub-module, lfsr16 (clk, reset, seed param, q[15:0]), reused later for sprite and randomised effects.

Test Plan:
(All use COOLDOWN_BASE=20, STEP=2, MIN=4, default geometry.)
- Reset/idle: release reset with enable=0 for 50 cycles -> fire never asserts; all outputs 0. Assert reset mid-S_SCAN -> outputs 0 in the same cycle.
- First shot: all vivo=1, shot_busy=0, speed=0, enable raised -> fire pulses once at cycle 23 after S_COOL entry; fire_row=4; fire_idx=52+fire_col; shots_fired=1.
- Column search: only col 5 rows 0..2 alive -> every shot has fire_col=5, fire_row=2, fire_idx=31; scan never exceeds 13 cycles.
- Empty formation: vivo=0 for 500 cycles -> no fire; state cycles S_COOL/S_PICK/S_SCAN.
- Busy and kill: shot_busy=1 held while in S_WAIT -> no fire.
  - Clear the target bit while waiting -> rescan to a new target.
  - Drop shot_busy -> fire on the next cycle with the new idx.
- Speed and enable: speed=10 -> spacing between successive fires is 4+3 cycles (floor). enable=0 mid-S_COOL -> no fire, outputs hold; re-enable -> full 20-cycle cooldown restarts.

Source files
------------

// File: rtl/space_invaders_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | space_invaders_pkg : shared formation geometry, FSM states, LFSR |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package space_invaders_pkg;

  localparam int unsigned COLUNAS = 13;
  localparam int unsigned LINHAS  = 5;

  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_COOL = 3'd1,
    S_PICK = 3'd2,
    S_SCAN = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lfsr16 : free-running 16-bit Galois LFSR, advances every clock   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);
  import space_invaders_pkg::*;

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb q_d = lfsr_next(q_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/enemy_fire_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | enemy_fire_scheduler : picks a random column, targets its lowest |
// | live enemy and launches the single enemy shot when it is free.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module enemy_fire_scheduler #(
  parameter int unsigned COLUNAS       = space_invaders_pkg::COLUNAS,
  parameter int unsigned LINHAS        = space_invaders_pkg::LINHAS,
  parameter int unsigned COOLDOWN_BASE = 5000000,
  parameter int unsigned COOLDOWN_STEP = 250000,
  parameter int unsigned COOLDOWN_MIN  = 1000000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [LINHAS*COLUNAS-1:0] vivo,
  input  logic                      shot_busy,
  input  logic [4:0]                speed,
  output logic                      fire,
  output logic [3:0]                fire_col,
  output logic [2:0]                fire_row,
  output logic [6:0]                fire_idx,
  output logic [15:0]               shots_fired
);
  import space_invaders_pkg::*;

  localparam int unsigned IW = $clog2(LINHAS * COLUNAS);

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    tries_q, tries_d;
  logic [3:0]    tgt_col_q, tgt_col_d;
  logic [2:0]    tgt_row_q, tgt_row_d;
  logic          fire_q, fire_d;
  logic [3:0]    fire_col_q, fire_col_d;
  logic [2:0]    fire_row_q, fire_row_d;
  logic [6:0]    fire_idx_q, fire_idx_d;
  logic [15:0]   shots_q, shots_d;

  logic [15:0]   lfsr;
  logic          lfsr_unused;
  logic [31:0]   prod;
  logic [31:0]   eff;
  logic [3:0]    start;
  logic          hit;
  logic [2:0]    hit_row;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] tgt_idx;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:4];

  // Effective cooldown with floor; product overflow past base also floors.
  always_comb begin
    prod = 32'(speed) * COOLDOWN_STEP;
    if (prod >= COOLDOWN_BASE || (COOLDOWN_BASE - prod) < COOLDOWN_MIN) eff = COOLDOWN_MIN;
    else                                                              eff = COOLDOWN_BASE - prod;
  end

  always_comb begin
    if (32'(lfsr[3:0]) >= COLUNAS) start = 4'(32'(lfsr[3:0]) - COLUNAS);
    else                           start = lfsr[3:0];
  end

  // Lowest (highest-numbered) live row in the column under scan.
  always_comb begin
    hit      = 1'b0;
    hit_row  = 3'd0;
    scan_idx = '0;
    for (int r = 0; r < LINHAS; r++) begin
      scan_idx = IW'(r * COLUNAS) + IW'(col_q);
      if (vivo[scan_idx]) begin
        hit     = 1'b1;
        hit_row = 3'(r);
      end
    end
  end

  assign tgt_idx = IW'(tgt_row_q) * IW'(COLUNAS) + IW'(tgt_col_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    tries_d    = tries_q;
    tgt_col_d  = tgt_col_q;
    tgt_row_d  = tgt_row_q;
    fire_d     = 1'b0;
    fire_col_d = fire_col_q;
    fire_row_d = fire_row_q;
    fire_idx_d = fire_idx_q;
    shots_d    = shots_q;

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_COOL;
          cnt_d   = eff - 32'd1;
        end
        S_COOL: begin
          if (cnt_q == 32'd0) state_d = S_PICK;
          else                cnt_d   = cnt_q - 32'd1;
        end
        S_PICK: begin
          col_d   = start;
          tries_d = 4'd0;
          state_d = S_SCAN;
        end
        S_SCAN: begin
          if (hit) begin
            tgt_col_d = col_q;
            tgt_row_d = hit_row;
            state_d   = S_WAIT;
          end else if (tries_q == 4'(COLUNAS - 1)) begin
            state_d = S_COOL;
            cnt_d   = eff - 32'd1;
          end else begin
            col_d   = (col_q == 4'(COLUNAS - 1)) ? 4'd0 : col_q + 4'd1;
            tries_d = tries_q + 4'd1;
          end
        end
        S_WAIT: begin
          // A kill on the same sample as the shot freeing up takes priority.
          if (!vivo[tgt_idx]) begin
            state_d = S_PICK;
          end else if (!shot_busy) begin
            fire_d     = 1'b1;
            fire_col_d = tgt_col_q;
            fire_row_d = tgt_row_q;
            fire_idx_d = 7'(tgt_idx);
            shots_d    = shots_q + 16'd1;
            state_d    = S_COOL;
            cnt_d      = eff - 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      col_q      <= 4'd0;
      tries_q    <= 4'd0;
      tgt_col_q  <= 4'd0;
      tgt_row_q  <= 3'd0;
      fire_q     <= 1'b0;
      fire_col_q <= 4'd0;
      fire_row_q <= 3'd0;
      fire_idx_q <= 7'd0;
      shots_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      tries_q    <= tries_d;
      tgt_col_q  <= tgt_col_d;
      tgt_row_q  <= tgt_row_d;
      fire_q     <= fire_d;
      fire_col_q <= fire_col_d;
      fire_row_q <= fire_row_d;
      fire_idx_q <= fire_idx_d;
      shots_q    <= shots_d;
    end
  end

  assign fire        = fire_q;
  assign fire_col    = fire_col_q;
  assign fire_row    = fire_row_q;
  assign fire_idx    = fire_idx_q;
  assign shots_fired = shots_q;

endmodule
`default_nettype wire
